// File: rtl/comp_pkg.sv
// Shared types for the serial five-operand accumulator.
// Holds the controller state encoding and the column-count helper.
package comp_pkg;

   typedef enum logic [1:0] {
      IDLE,
      COMPRESS,
      ADD,
      DONE
   } state_t;

   // Columns needed to hold the exact sum of five WIDTH-bit operands.
   function automatic int calc_n(input int w);
      return w + 3;
   endfunction

endpackage

// File: rtl/compressor5to1.sv
// Combinational 5:2 compressor cell.
// Cout1/Cout2 come only from x1..x5; Cin1/Cin2 enter the final full adder.
module compressor5to1 (
   input  logic x1,
   input  logic x2,
   input  logic x3,
   input  logic x4,
   input  logic x5,
   input  logic Cin1,
   input  logic Cin2,
   output logic Sum,
   output logic Carry,
   output logic Cout1,
   output logic Cout2
);

   logic w_s1;
   logic w_s2;

   // Two chained full adders on the operands, a third folds in the carries.
   always_comb begin
      w_s1  = x1 ^ x2 ^ x3;
      Cout1 = (x1 & x2) | (x1 & x3) | (x2 & x3);
      w_s2  = w_s1 ^ x4 ^ x5;
      Cout2 = (w_s1 & x4) | (w_s1 & x5) | (x4 & x5);
      Sum   = w_s2 ^ Cin1 ^ Cin2;
      Carry = (w_s2 & Cin1) | (w_s2 & Cin2) | (Cin1 & Cin2);
   end

endmodule

// File: rtl/comp5_serial_accumulator.sv
// Bit-serial adder of five unsigned operands through one 5:2 cell.
// Columns are compressed LSB-first, then S and C are summed in one cycle.
module comp5_serial_accumulator
   import comp_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH-1:0]   op1,
   input  logic [WIDTH-1:0]   op2,
   input  logic [WIDTH-1:0]   op3,
   input  logic [WIDTH-1:0]   op4,
   input  logic [WIDTH-1:0]   op5,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [WIDTH+2:0]   result,
   output logic               busy
);

   localparam int N  = calc_n(WIDTH);
   localparam int CW = $clog2(N);
   localparam logic [CW-1:0] LAST = CW'(N - 1);

   state_t          r_state;
   state_t          w_state_nx;
   logic [N-1:0]    r_sh [5];
   logic [N-1:0]    r_s;
   logic [N-1:0]    r_c;
   logic [N-1:0]    r_res;
   logic [CW-1:0]   r_cnt;
   logic [CW-1:0]   w_cnt_nx;
   logic            r_cin1;
   logic            r_cin2;
   logic            w_sum;
   logic            w_carry;
   logic            w_cout1;
   logic            w_cout2;

   compressor5to1 u_cell (
      r_sh[0][0], r_sh[1][0], r_sh[2][0], r_sh[3][0], r_sh[4][0],
      r_cin1, r_cin2,
      w_sum, w_carry, w_cout1, w_cout2
   );

   assign w_cnt_nx = r_cnt + 1'b1;
   assign result   = r_res;

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_state_nx;
   end

   // Next-state and handshake outputs.
   always_comb begin
      w_state_nx = r_state;
      in_ready   = 1'b0;
      out_valid  = 1'b0;
      busy       = 1'b1;
      unique case (r_state)
         IDLE: begin
            in_ready = 1'b1;
            busy     = 1'b0;
            if (in_valid) w_state_nx = COMPRESS;
         end
         COMPRESS: if (r_cnt == LAST) w_state_nx = ADD;
         ADD:      w_state_nx = DONE;
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) w_state_nx = IDLE;
         end
         default:  w_state_nx = IDLE;
      endcase
   end

   // Operand capture, column compression and final carry-propagate add.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 5; i++) r_sh[i] <= '0;
         r_s    <= '0;
         r_c    <= '0;
         r_res  <= '0;
         r_cnt  <= '0;
         r_cin1 <= 1'b0;
         r_cin2 <= 1'b0;
      end else begin
         unique case (r_state)
            IDLE: if (in_valid) begin
               r_sh[0] <= N'(op1);
               r_sh[1] <= N'(op2);
               r_sh[2] <= N'(op3);
               r_sh[3] <= N'(op4);
               r_sh[4] <= N'(op5);
               r_s     <= '0;
               r_c     <= '0;
               r_cnt   <= '0;
               r_cin1  <= 1'b0;
               r_cin2  <= 1'b0;
            end
            COMPRESS: begin
               r_s[r_cnt] <= w_sum;
               if (r_cnt != LAST) begin
                  r_c[w_cnt_nx] <= w_carry;
                  r_cnt         <= w_cnt_nx;
               end
               r_cin1 <= w_cout1;
               r_cin2 <= w_cout2;
               for (int i = 0; i < 5; i++) r_sh[i] <= r_sh[i] >> 1;
            end
            ADD:     r_res <= r_s + r_c;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_comp5_serial_accumulator.sv
// Randomised self-checking bench for comp5_serial_accumulator.
// Expected sums come from plain integer addition of the operands.
module tb_comp5_serial_accumulator;
   import comp_pkg::*;

   localparam int W = 8;
   localparam int N = W + 3;

   logic          clk;
   logic          rst_n;
   logic          in_valid;
   logic          in_ready;
   logic [W-1:0]  op1, op2, op3, op4, op5;
   logic          out_valid;
   logic          out_ready;
   logic [N-1:0]  result;
   logic          busy;

   int checks   = 0;
   int failures = 0;

   comp5_serial_accumulator #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .op1       (op1),
      .op2       (op2),
      .op3       (op3),
      .op4       (op4),
      .op5       (op5),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int ref_sum(input int a, b, c, d, e);
      return a + b + c + d + e;
   endfunction

   // One full transaction; returns observations for the caller to judge.
   task automatic run_txn(
      input  int a, b, c, d, e,
      input  int stall,
      output int res,
      output int lat,
      output bit stable,
      output bit cin0,
      output bit idle_after,
      output time t_acc
   );
      int g;
      g = 0;
      while (!in_ready && g < 60) begin
         @(posedge clk); #1; g++;
      end
      op1 = W'(a); op2 = W'(b); op3 = W'(c); op4 = W'(d); op5 = W'(e);
      in_valid = 1'b1;
      @(posedge clk);
      t_acc = $time;
      #1;
      in_valid = 1'b0;
      op1 = W'($urandom); op2 = W'($urandom); op3 = W'($urandom);
      op4 = W'($urandom); op5 = W'($urandom);
      out_ready = 1'b0;
      lat = -1;
      cin0 = 1'b1;
      for (int k = 1; k <= 40; k++) begin
         @(posedge clk); #1;
         if (dut.r_state == COMPRESS && dut.r_cnt == 4'(N - 1) && dut.w_carry)
            cin0 = 1'b0;
         if (dut.r_state == ADD && (dut.r_cin1 || dut.r_cin2))
            cin0 = 1'b0;
         if (out_valid) begin
            lat = k;
            break;
         end
      end
      res = int'(result);
      stable = 1'b1;
      idle_after = 1'b0;
      if (lat > 0) begin
         repeat (stall) begin
            @(posedge clk); #1;
            if (!out_valid || int'(result) != res) stable = 1'b0;
         end
         out_ready = 1'b1;
         @(posedge clk); #1;
         out_ready = 1'b0;
         idle_after = in_ready && !out_valid && !busy;
      end
   endtask

   task automatic test_reset;
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      op1 = '0; op2 = '0; op3 = '0; op4 = '0; op5 = '0;
      #23;
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || result !== '0) begin
         failures++;
         $display("FAIL reset: in_ready=%b out_valid=%b busy=%b result=%0d want 1 0 0 0",
                  in_ready, out_valid, busy, result);
      end
      rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_zero;
      int r, l; bit s, c0, ia; time t;
      run_txn(0, 0, 0, 0, 0, 0, r, l, s, c0, ia, t);
      checks++;
      if (r != 0) begin
         failures++; $display("FAIL zero_result: got %0d want 0", r);
      end
      checks++;
      if (l != N + 1) begin
         failures++; $display("FAIL zero_latency: got %0d want %0d", l, N + 1);
      end
      checks++;
      if (!ia) begin
         failures++; $display("FAIL zero_idle_after: got 0 want 1");
      end
   endtask

   task automatic test_max;
      int r, l; bit s, c0, ia; time t;
      run_txn(255, 255, 255, 255, 255, 0, r, l, s, c0, ia, t);
      checks++;
      if (r != 1275) begin
         failures++; $display("FAIL max_result: got %0d want 1275", r);
      end
      checks++;
      if (!c0) begin
         failures++; $display("FAIL max_carries_zero: got nonzero want 0");
      end
   endtask

   task automatic test_back_to_back;
      int r, l; bit s, c0, ia; time t0, t1;
      run_txn(1, 2, 3, 4, 5, 0, r, l, s, c0, ia, t0);
      checks++;
      if (r != 15) begin
         failures++; $display("FAIL small_result: got %0d want 15", r);
      end
      run_txn(8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 0, r, l, s, c0, ia, t1);
      checks++;
      if (r != 640) begin
         failures++; $display("FAIL b2b_result: got %0d want 640", r);
      end
      checks++;
      if (t1 - t0 != time'((N + 3) * 10)) begin
         failures++;
         $display("FAIL b2b_period: got %0t want %0d", t1 - t0, (N + 3) * 10);
      end
   endtask

   task automatic test_stall;
      int r, l; bit s, c0, ia; time t;
      run_txn(17, 99, 200, 3, 41, 20, r, l, s, c0, ia, t);
      checks++;
      if (r != ref_sum(17, 99, 200, 3, 41)) begin
         failures++; $display("FAIL stall_result: got %0d want %0d", r, ref_sum(17, 99, 200, 3, 41));
      end
      checks++;
      if (!s) begin
         failures++; $display("FAIL stall_stable: got unstable want stable");
      end
      checks++;
      if (!ia) begin
         failures++; $display("FAIL stall_idle_after: got 0 want 1");
      end
   endtask

   task automatic test_ignore_inval;
      int lat;
      bit rdy_seen;
      op1 = 8'd11; op2 = 8'd22; op3 = 8'd33; op4 = 8'd44; op5 = 8'd55;
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rdy_seen = 1'b0;
      op1 = 8'd200; op2 = 8'd200; op3 = 8'd200; op4 = 8'd200; op5 = 8'd200;
      in_valid = 1'b1;
      repeat (2) begin
         if (in_ready) rdy_seen = 1'b1;
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      checks++;
      if (rdy_seen) begin
         failures++; $display("FAIL ignore_in_ready: got 1 want 0");
      end
      lat = -1;
      for (int k = 0; k < 40; k++) begin
         if (out_valid) begin lat = k; break; end
         @(posedge clk); #1;
      end
      checks++;
      if (lat < 0 || result !== N'(165)) begin
         failures++; $display("FAIL ignore_result: got %0d want 165", result);
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
   endtask

   task automatic test_async_reset;
      int r, l, g; bit s, c0, ia; time t;
      op1 = 8'd7; op2 = 8'd7; op3 = 8'd7; op4 = 8'd7; op5 = 8'd7;
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      g = 0;
      while (!(dut.r_state == COMPRESS && dut.r_cnt == 4'd4) && g < 30) begin
         @(posedge clk); #1; g++;
      end
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if (g >= 30 || in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || result !== '0) begin
         failures++;
         $display("FAIL async_reset: in_ready=%b out_valid=%b busy=%b result=%0d want 1 0 0 0",
                  in_ready, out_valid, busy, result);
      end
      #4;
      rst_n = 1'b1;
      @(posedge clk); #1;
      run_txn(10, 20, 30, 40, 50, 0, r, l, s, c0, ia, t);
      checks++;
      if (r != 150) begin
         failures++; $display("FAIL post_reset_result: got %0d want 150", r);
      end
   endtask

   task automatic test_random;
      int a, b, c, d, e, r, l, exp;
      bit s, c0, ia; time t;
      for (int n = 0; n < 500; n++) begin
         a = $urandom_range(0, 255); b = $urandom_range(0, 255);
         c = $urandom_range(0, 255); d = $urandom_range(0, 255);
         e = $urandom_range(0, 255);
         exp = ref_sum(a, b, c, d, e);
         run_txn(a, b, c, d, e, $urandom_range(0, 3), r, l, s, c0, ia, t);
         checks++;
         if (r != exp || l != N + 1 || !s || !c0 || !ia) begin
            failures++;
            $display("FAIL random_%0d: got %0d lat %0d want %0d lat %0d (stable=%b carries0=%b idle=%b)",
                     n, r, l, exp, N + 1, s, c0, ia);
         end
      end
   endtask

   initial begin
      test_reset();
      test_zero();
      test_max();
      test_back_to_back();
      test_stall();
      test_ignore_inval();
      test_async_reset();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
